// File: rtl/serial_rx_pkg.sv
// Shared constants, FSM state type and helpers for the parametrised serial receiver.
package serial_rx_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned ERR_FRM = 0;
  localparam int unsigned ERR_PAR = 1;
  localparam int unsigned ERR_W   = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    PUSH
  } rx_state_t;

  // 2-of-3 majority used when bit voting is enabled
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Word FIFO with a first-word-fall-through output register; empty-path bypass gives 1-cycle latency.
module serial_rx_fifo #(
  parameter int unsigned W  = 10,
  parameter int unsigned AW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] data,
  output logic         full_c,
  output logic         stb,
  output logic [W-1:0] word,
  input  logic         ack
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;
  logic          empty_c;
  logic          load_c;
  logic          pop_c;
  logic          wr_c;

  assign full_c = (count == (AW+1)'(DEPTH));

  // An incoming word goes straight to the output register when nothing is queued ahead of it
  always_comb begin
    empty_c = (count == '0);
    load_c  = (!stb || ack) && (!empty_c || push);
    pop_c   = load_c && !empty_c;
    wr_c    = push && !(load_c && empty_c) && (!full_c || pop_c);
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem[wptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      stb   <= 1'b0;
      word  <= '0;
    end else begin
      if (wr_c)  wptr <= wptr + AW'(1);
      if (pop_c) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(wr_c) - (AW+1)'(pop_c);
      if (load_c) begin
        stb  <= 1'b1;
        word <= empty_c ? data : mem[rptr];
      end else if (ack) begin
        stb  <= 1'b0;
        word <= '0;
      end
    end
  end

endmodule

// File: rtl/serial_rx_fifo_box.sv
// Oversampling serial receiver with parity/stop checks, word FIFO and sticky overrun.
// Define SERIAL_RX_MAJORITY_VOTE_EN to decide each bit by a 3-sample majority vote.
module serial_rx_fifo_box
  import serial_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OVS         = 8,
  parameter int unsigned FIFO_AW     = 5,
  parameter int unsigned SYNC_STAGES = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              I_RxD,
  output logic              O_STB,
  output logic [DATA_W-1:0] O_DATA,
  output logic [1:0]        O_ERR,
  input  logic              O_ACK,
  output logic              O_OVR,
  input  logic              I_OVR_CLR,
  input  logic [15:0]       CFG_CLK_DIV,
  input  logic [1:0]        CFG_PARITY,
  input  logic              CFG_STOP2
);

  localparam int unsigned PH_W   = $clog2(OVS);
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned WORD_W = DATA_W + ERR_W;
  localparam logic [PH_W-1:0] PH_MID = PH_W'(OVS / 2);

  rx_state_t               state;
  rx_state_t               state_nx;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_bit;
  logic [15:0]             cfg_div;
  logic [1:0]              cfg_par;
  logic                    cfg_stop2;
  logic                    par_en;
  logic [15:0]             div_cnt;
  logic [PH_W-1:0]         phase;
  logic                    tick_c;
  logic                    sample_c;
  logic                    bit_c;
  logic [DATA_W-1:0]       shreg;
  logic [DATA_W-1:0]       shreg_nx;
  logic [CNT_W-1:0]        bit_cnt;
  logic [CNT_W-1:0]        bit_cnt_nx;
  logic                    par_err;
  logic                    par_err_nx;
  logic                    frm_err;
  logic                    frm_err_nx;
  logic                    wait_high;
  logic                    wait_high_nx;
  logic                    push_c;
  logic [ERR_W-1:0]        errs_c;
  logic                    full_c;
  logic                    ovr_set_c;
  logic [WORD_W-1:0]       out_word;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], I_RxD};
  end
  assign rx_bit = sync_q[SYNC_STAGES-1];

  // Configuration is frozen for the duration of a frame
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cfg_div   <= 16'd1;
      cfg_par   <= PAR_NONE;
      cfg_stop2 <= 1'b0;
    end else if (state == IDLE) begin
      cfg_div   <= (CFG_CLK_DIV == 16'd0) ? 16'd1 : CFG_CLK_DIV;
      cfg_par   <= CFG_PARITY;
      cfg_stop2 <= CFG_STOP2;
    end
  end
  assign par_en = (cfg_par == PAR_EVEN) || (cfg_par == PAR_ODD);

  assign tick_c = (state != IDLE) && (div_cnt == cfg_div);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= 16'd1;
      phase   <= '0;
    end else if (state == IDLE) begin
      div_cnt <= 16'd1;
      phase   <= '0;
    end else if (tick_c) begin
      div_cnt <= 16'd1;
      phase   <= phase + PH_W'(1);
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

`ifdef SERIAL_RX_MAJORITY_VOTE_EN
  logic vote_a;
  logic vote_b;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else begin
      if (tick_c && (phase == PH_MID - PH_W'(1))) vote_a <= rx_bit;
      if (tick_c && (phase == PH_MID))            vote_b <= rx_bit;
    end
  end
  assign sample_c = tick_c && (phase == PH_MID + PH_W'(1));
  assign bit_c    = maj3(vote_a, vote_b, rx_bit);
`else
  assign sample_c = tick_c && (phase == PH_MID);
  assign bit_c    = rx_bit;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      wait_high <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      bit_cnt   <= bit_cnt_nx;
      par_err   <= par_err_nx;
      frm_err   <= frm_err_nx;
      wait_high <= wait_high_nx;
    end
  end

  // Frame sequencing; after a framing error the line must go high before re-arming
  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    bit_cnt_nx   = bit_cnt;
    par_err_nx   = par_err;
    frm_err_nx   = frm_err;
    wait_high_nx = wait_high;
    push_c       = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_bit)          wait_high_nx = 1'b0;
        else if (!wait_high) state_nx     = START;
      end
      START: if (sample_c) begin
        if (bit_c) begin
          state_nx = IDLE;
        end else begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
          par_err_nx = 1'b0;
          frm_err_nx = 1'b0;
        end
      end
      DATA: if (sample_c) begin
        shreg_nx   = {bit_c, shreg[DATA_W-1:1]};
        bit_cnt_nx = bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(DATA_W - 1)) state_nx = par_en ? PARITY : STOP1;
      end
      PARITY: if (sample_c) begin
        par_err_nx = ((^shreg) ^ bit_c) != (cfg_par == PAR_ODD);
        state_nx   = STOP1;
      end
      STOP1: if (sample_c) begin
        frm_err_nx = ~bit_c;
        state_nx   = cfg_stop2 ? STOP2 : PUSH;
      end
      STOP2: if (sample_c) begin
        frm_err_nx = frm_err | ~bit_c;
        state_nx   = PUSH;
      end
      PUSH: begin
        push_c       = 1'b1;
        wait_high_nx = frm_err;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    errs_c          = '0;
    errs_c[ERR_FRM] = frm_err;
    errs_c[ERR_PAR] = par_err;
  end

  serial_rx_fifo #(
    .W  (WORD_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk    (CLK),
    .rst_n  (RST_N),
    .push   (push_c),
    .data   ({errs_c, shreg}),
    .full_c (full_c),
    .stb    (O_STB),
    .word   (out_word),
    .ack    (O_ACK)
  );

  assign O_DATA = out_word[DATA_W-1:0];
  assign O_ERR  = out_word[WORD_W-1:DATA_W];

  // A full FIFO only frees a slot this cycle if the output register is being emptied
  assign ovr_set_c = push_c && full_c && O_STB && !O_ACK;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         O_OVR <= 1'b0;
    else if (ovr_set_c) O_OVR <= 1'b1;
    else if (I_OVR_CLR) O_OVR <= 1'b0;
  end

endmodule

// File: doc/serial_rx_fifo_box.md
Name: serial_rx_fifo_box

Overview:
- Parametrised successor to the team's fixed 8N1 UART receiver.
- Configurable data width, parity, stop bits, oversampling ratio and FIFO depth, with per-word error flags, false-start rejection and overrun reporting.
- Sits between an external RxD pin and a strobe/ack byte consumer. Drop-in for the existing UART subsystem.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- OVS, 8, oversample ticks per bit; power of 2, 4..16.
- FIFO_AW, 5, FIFO address width; depth = 2**FIFO_AW words.
- SYNC_STAGES, 4, input synchroniser/filter stages; minimum 2.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset; asynchronous, active-low
- I_RxD  in  1  serial line, async to CLK, idle high
- O_STB  out  1  output word valid (level)
- O_DATA  out  DATA_W  received word, LSB = first bit on line
- O_ERR  out  2  {parity_err, framing_err} for the word on O_DATA
- O_ACK  in  1  consumer accepts the word when O_STB && O_ACK
- O_OVR  out  1  sticky overrun flag
- I_OVR_CLR  in  1  one-cycle pulse; clears O_OVR
- CFG_CLK_DIV  in  16  CLK cycles per oversample tick; 0 is treated as 1
- CFG_PARITY  in  2  00 none, 01 even, 10 odd, 11 none
- CFG_STOP2  in  1  1 = two stop bits expected

Behaviour:
- Reset (RST_N low, async): FSM=IDLE, synchroniser all 1s, O_STB=0, O_DATA=0, O_ERR=0, O_OVR=0, FIFO empty.
- Config ports are sampled only while in IDLE. Changes mid-frame take effect on the next frame.
- Synchroniser: shift register of SYNC_STAGES flops; rx_bit is its last stage.
- Scaler: divider counts 1..CFG_CLK_DIV and emits a tick on match, then reloads 1. Phase counter of log2(OVS) bits increments on each tick, mod OVS. Both counters are held at 1/0 while in IDLE.
- Sample event = tick while phase == OVS/2. The first sample falls OVS/2+1 ticks after start detection; later samples are every OVS ticks.
- FSM states and transitions:
  - IDLE: rx_bit==0 -> START.
  - START: at sample, rx_bit==1 -> IDLE (false start, nothing pushed); else -> DATA.
  - DATA: shifts rx_bit in LSB-first over DATA_W samples, then -> PARITY if parity is enabled, else -> STOP1.
  - PARITY: at sample, parity_err = (XOR of data ^ rx_bit) != (odd ? 1 : 0); -> STOP1.
  - STOP1: at sample, framing_err = ~rx_bit; -> STOP2 if CFG_STOP2, else -> PUSH.
  - STOP2: at sample, framing_err |= ~rx_bit; -> PUSH.
  - PUSH: one cycle; writes {errs, data} to the FIFO; -> IDLE.
- A word with errors is still pushed, carrying its flags.
- After a framing error, IDLE waits for rx_bit==1 before re-arming, so a break condition does not generate repeated frames.
- FIFO: circular buffer with read/write pointers and an FIFO_AW+1-bit count.
  - Push while full (and no same-cycle pop): word dropped, O_OVR set.
  - Push and pop in the same cycle while full: both succeed.
  - I_OVR_CLR together with a new overrun: set wins.
- Output register (first-word-fall-through):
  - Loads from the FIFO when (O_ACK && O_STB) || !O_STB and the FIFO is non-empty.
  - Latency is 1 cycle from PUSH to O_STB when the FIFO and output register are both empty.
  - If O_ACK is taken with the FIFO empty, O_STB, O_DATA and O_ERR clear to 0 on the next cycle.
  - O_ACK while !O_STB is ignored.
  - Back-to-back ACKs drain one word per cycle.
- Unused O_DATA bits: none; O_DATA is exactly DATA_W wide.

Optional Feature:
- Macro: SERIAL_RX_MAJORITY_VOTE_EN.
- Defined: each bit value is the 2-of-3 majority of rx_bit captured at phase OVS/2-1, OVS/2 and OVS/2+1. The decision is applied at phase OVS/2+1, so state transitions occur one tick later than the base timing. The START false-start check uses the voted value.
- Undefined: single sample at phase OVS/2, as described in Behaviour.

Decomposition:
- Package serial_rx_pkg holds:
  - Parity encoding constants: PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10.
  - FSM state enum: IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH.
  - ERR bit index constants: ERR_FRM=0, ERR_PAR=1.
- Sub-module serial_rx_fifo holds the FIFO plus output register. Its interface is push/data/full in, and O_STB/O_ACK out; overrun is computed in the parent.

Test Plan:
- CFG_CLK_DIV=4, OVS=8, 8N1, send 0xA5 -> O_STB rises 1 cycle after PUSH, O_DATA=0xA5, O_ERR=00; after O_ACK, O_STB=0 and O_DATA=0.
- Even parity, send 0x3C with parity bit 1 -> O_DATA=0x3C, O_ERR=2'b10. Repeat with parity bit 0 -> O_ERR=2'b00.
- 8N2, send 0x55 with the second stop bit driven 0 -> O_DATA=0x55, O_ERR=2'b01. Line held low afterwards -> no further words until the line returns high.
- Low glitch of 2 oversample ticks on an idle line -> FSM returns to IDLE, O_STB never asserted.
- FIFO_AW=2, O_ACK=0, send 6 bytes 0x01..0x06 -> output register holds 0x01, FIFO holds 0x02..0x05, 0x06 dropped, O_OVR=1. Drain with O_ACK held high -> 0x01..0x05 on consecutive cycles. I_OVR_CLR pulse -> O_OVR=0.
- Assert RST_N low mid-DATA of a 0xFF frame -> all outputs 0 immediately. Release during idle line, send 0x81 -> O_DATA=0x81, O_ERR=00.
